// File: rtl/user_insn_dispatch.sv
// user_insn_dispatch
//   Dispatches lm32 user instructions to one of NUM_UNITS coprocessor units.
//   A unit-select field in the opcode picks the target unit. The opcode and
//   operands are forwarded on shared registered buses, and each instruction
//   gets exactly one registered result and one completion pulse. A timeout
//   also guarantees that response if the unit never answers.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   user_valid         : CPU request, held with stable payload until user_complete
//   user_opcode        : user opcode; select field at [SEL_LSB +: SELW]
//   user_operand_0/1   : CPU operands
//   user_result        : registered result, valid while user_complete is high
//   user_complete      : one-cycle completion pulse
//   u_valid            : one-hot request to the units
//   u_opcode           : shared registered opcode to the units
//   u_operand_0/1      : shared registered operands to the units
//   u_result           : packed unit results, unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   u_complete         : per-unit done
//   err_timeout        : one-cycle pulse when a timeout fires
//   err_count          : saturating count of timeouts and invalid-unit requests
module user_insn_dispatch #(
   parameter int unsigned               NUM_UNITS    = 4,
   parameter int unsigned               OPCODE_WIDTH = 11,
   parameter int unsigned               DATA_WIDTH   = 32,
   parameter int unsigned               SEL_LSB      = 8,
   parameter int unsigned               TIMEOUT      = 1024,
   parameter logic [DATA_WIDTH-1:0]     ERR_RESULT   = 32'hDEAD_BEEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              user_valid,
   input  logic [OPCODE_WIDTH-1:0]           user_opcode,
   input  logic [DATA_WIDTH-1:0]             user_operand_0,
   input  logic [DATA_WIDTH-1:0]             user_operand_1,
   output logic [DATA_WIDTH-1:0]             user_result,
   output logic                              user_complete,
   output logic [NUM_UNITS-1:0]              u_valid,
   output logic [OPCODE_WIDTH-1:0]           u_opcode,
   output logic [DATA_WIDTH-1:0]             u_operand_0,
   output logic [DATA_WIDTH-1:0]             u_operand_1,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0]   u_result,
   input  logic [NUM_UNITS-1:0]              u_complete,
   output logic                              err_timeout,
   output logic [15:0]                       err_count
);

   localparam int unsigned SELW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int unsigned CNTW = $clog2(TIMEOUT);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_DRAIN
   } state_t;

   state_t                state;
   logic [SELW-1:0]       sel;
   logic [CNTW-1:0]       cnt;

   logic [SELW-1:0]       req_sel;
   logic                  req_ok;
   logic [NUM_UNITS-1:0]  req_onehot;
   logic                  sel_done;
   logic [DATA_WIDTH-1:0] sel_result;

   // Decode of the incoming request and mux of the selected unit's response.
   // A select value at or above NUM_UNITS matches no unit and flags the request invalid.
   always_comb begin
      req_sel    = user_opcode[SEL_LSB +: SELW];
      req_ok     = (32'(req_sel) < NUM_UNITS);
      req_onehot = '0;
      sel_done   = 1'b0;
      sel_result = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (SELW'(i) == req_sel) begin
            req_onehot[i] = 1'b1;
         end
         if (SELW'(i) == sel) begin
            sel_done   = u_complete[i];
            sel_result = u_result[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         sel           <= '0;
         cnt           <= '0;
         user_result   <= '0;
         user_complete <= 1'b0;
         u_valid       <= '0;
         u_opcode      <= '0;
         u_operand_0   <= '0;
         u_operand_1   <= '0;
         err_timeout   <= 1'b0;
         err_count     <= '0;
      end else begin
         user_complete <= 1'b0;
         err_timeout   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (user_valid) begin
                  u_opcode    <= user_opcode;
                  u_operand_0 <= user_operand_0;
                  u_operand_1 <= user_operand_1;
                  sel         <= req_sel;
                  if (req_ok) begin
                     u_valid <= req_onehot;
                     cnt     <= '0;
                     state   <= S_WAIT;
                  end else begin
                     user_result   <= ERR_RESULT;
                     user_complete <= 1'b1;
                     err_count     <= (err_count == '1) ? err_count : err_count + 16'd1;
                     state         <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               // Abort beats completion, and completion beats timeout.
               if (!user_valid) begin
                  u_valid <= '0;
                  state   <= S_IDLE;
               end else if (sel_done) begin
                  user_result   <= sel_result;
                  user_complete <= 1'b1;
                  u_valid       <= '0;
                  state         <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  user_result   <= ERR_RESULT;
                  user_complete <= 1'b1;
                  err_timeout   <= 1'b1;
                  err_count     <= (err_count == '1) ? err_count : err_count + 16'd1;
                  u_valid       <= '0;
                  state         <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: begin
               state <= S_DRAIN;
            end
            S_DRAIN: begin
               // A request still held after its response must not be issued a second time.
               if (!user_valid) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
